fixed_divider: RTL and testbench
================================

# fixed_divider

Sequential unsigned Q16.16 fixed-point divider, the inverse of the combinational Q16.16 multiplier in the datapath. It accepts a dividend and a divisor, each supplied as 16-bit integer and fraction halves. A restoring shift-subtract loop produces one quotient bit per cycle, and the result comes out in the same Q16.16 split format. It sits beside the multiplier in the arithmetic unit and is driven by a start/done handshake from the controller.

## Interface
- No parameters; widths are fixed (Q16.16 operands and result).
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request a division; sampled only in IDLE
- a  in  16  dividend integer part
- b  in  16  dividend fraction part
- c  in  16  divisor integer part
- d  in  16  divisor fraction part
- busy  out  1  high while iterating (state CALC)
- done  out  1  one-cycle pulse; result valid
- div0  out  1  last division had divisor 0; held until next accepted start
- ovf  out  1  last quotient exceeded 32 bits and was saturated; held until next accepted start
- result  out  32  Q16.16 quotient; held until next accepted start
- resultE  out  16  result[31:16]
- resultF  out  16  result[15:0]

## Operation
- States: IDLE, CALC, DONE.
- **IDLE, start=1, {c,d}≠0:**
  - Latch N = {a,b,16'h0} (48 bits) and D = {c,d} (32 bits).
  - Clear the remainder register R (33 bits) and the quotient register Q (48 bits).
  - Load the iteration counter with the iteration count; go to CALC.
  - Clear div0 and ovf.
- **IDLE, start=1, {c,d}=0:**
  - Go to DONE directly.
  - Set div0=1, ovf=0, result=32'hFFFF_FFFF.
- **CALC, each cycle:**
  - Form R' = {R[31:0], N[47]}; shift N left by 1.
  - If R' ≥ D: R = R' − D and shift 1 into Q.
  - Otherwise: R = R' and shift 0 into Q.
  - Decrement the counter; go to DONE when the counter reaches 0.
- **CALC → DONE:**
  - If Q[47:32]≠0: result=32'hFFFF_FFFF, ovf=1.
  - Otherwise: result=Q[31:0].
- **DONE:**
  - done=1 for exactly one cycle, then go to IDLE.
- start is ignored in CALC and DONE. It is not queued, and operands are not re-sampled.
- Input a/b/c/d changes after acceptance have no effect.
- **Reset** (any state, including mid-CALC):
  - Next state IDLE, counter and internal registers cleared.
  - busy=0, done=0, div0=0, ovf=0, result=0.
- All arithmetic is unsigned. No sign handling.

## Timing
- Reset values: busy=0, done=0, div0=0, ovf=0, result=32'h0 (resultE=resultF=0).
- Let start be accepted in cycle 0 (IDLE).
- Normal division (truncating build):
  - Cycles 1–48: CALC, busy=1.
  - Cycle 49: DONE, busy=0, done=1, result valid.
  - Cycle 50: IDLE; the next start can be accepted from cycle 50 on.
- Divide by zero: DONE in cycle 1 with done=1 and div0=1; IDLE in cycle 2.
- result/div0/ovf update on the same edge that enters DONE. They stay stable until the edge after the next accepted start.
- Back-to-back: start held high continuously gives one division per 50 cycles (51 with rounding).

## Configuration
- Macro: FIXDIV_ROUND_EN.
- **Undefined:**
  - 48 iterations.
  - Quotient truncated toward zero.
- **Defined:**
  - 49 iterations; N is extended with one extra 0 LSB, so Q carries one guard bit.
  - Final result = Q[48:1] + Q[0], i.e. round half up.
  - A rounding carry that makes the result exceed 32 bits saturates to 32'hFFFF_FFFF with ovf=1.
  - Latency becomes DONE in cycle 50; the divide-by-zero path is unchanged.

## Test plan
- Reset held 2 cycles, then released → busy=done=div0=ovf=0, result=0. No done pulse without start.
- 1.5/0.5: a=1, b=16'h8000, c=0, d=16'h8000, start in cycle 0 → done in cycle 49 only, result=32'h0003_0000, resultE=3, resultF=0, ovf=0.
- 2/3: a=2, b=0, c=3, d=0:
  - Truncating build → result=32'h0000_AAAA.
  - FIXDIV_ROUND_EN build → result=32'h0000_AAAB, done in cycle 50.
- Divide by zero: a=5, c=d=0 → done in cycle 1, div0=1, result=32'hFFFF_FFFF. Next division 10/4 (a=10, c=4) → div0 cleared, result=32'h0002_8000.
- Overflow: a=16'h8000, b=0, c=0, d=1 → done in cycle 49, ovf=1, result=32'hFFFF_FFFF.
- Start pulses in cycles 5 and 30 during a running 10/4, then rst=1 in cycle 20 of a second division:
  - First division → the extra starts are ignored; one done in cycle 49 with the 10/4 result.
  - Second division → the edge after rst gives IDLE, all outputs 0, and no done pulse ever follows.
  - After reset release, a fresh start completes normally.

Source files
------------

// File: rtl/fixed_divider.sv
// fixed_divider: sequential unsigned Q16.16 restoring divider with start/done handshake.
// One quotient bit per cycle; divide-by-zero short-circuits straight to DONE.
// Optional build macro FIXDIV_ROUND_EN adds a guard bit and rounds half up;
// when it is undefined the quotient is truncated toward zero.
module fixed_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic        ovf,
  output logic [31:0] result,
  output logic [15:0] resultE,
  output logic [15:0] resultF
);

`ifdef FIXDIV_ROUND_EN
  localparam int unsigned N_W = 49;
`else
  localparam int unsigned N_W = 48;
`endif
  localparam int unsigned ITERS = N_W;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned D_W   = 32;
  localparam int unsigned R_W   = 33;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [N_W-1:0]     q_q, q_d;
  logic [D_W-1:0]     dd_q, dd_d;
  logic [R_W-1:0]     r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        result_q, result_d;

  logic [R_W:0]       r_shift;
  logic               sub_ok;
  logic [N_W-1:0]     q_step;
  logic               fin_ovf;
  logic [31:0]        fin_res;
`ifdef FIXDIV_ROUND_EN
  logic [48:0]        rnd;
`endif

  // Next-state, datapath step and registered-output computation.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    q_d      = q_q;
    dd_d     = dd_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;

    // R is always below D, so the 34-bit shifted remainder never loses its top bit.
    r_shift = {r_q, n_q[N_W-1]};
    sub_ok  = (r_shift >= {2'b00, dd_q});
    q_step  = N_W'({q_q, sub_ok});
`ifdef FIXDIV_ROUND_EN
    rnd     = {1'b0, q_step[48:1]} + {48'd0, q_step[0]};
    fin_ovf = |rnd[48:32];
    fin_res = rnd[31:0];
`else
    fin_ovf = |q_step[47:32];
    fin_res = q_step[31:0];
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          if ({c, d} == 32'h0) begin
            state_d  = DONE;
            div0_d   = 1'b1;
            ovf_d    = 1'b0;
            result_d = 32'hFFFF_FFFF;
          end else begin
            state_d = CALC;
            n_d     = {a, b, {(N_W - 32){1'b0}}};
            dd_d    = {c, d};
            r_d     = '0;
            q_d     = '0;
            cnt_d   = CNT_W'(ITERS);
            div0_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      CALC: begin
        n_d   = N_W'({n_q, 1'b0});
        q_d   = q_step;
        r_d   = sub_ok ? R_W'(r_shift - {2'b00, dd_q}) : R_W'(r_shift);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          ovf_d    = fin_ovf;
          result_d = fin_ovf ? 32'hFFFF_FFFF : fin_res;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      q_q      <= '0;
      dd_q     <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      q_q      <= q_d;
      dd_q     <= dd_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign div0    = div0_q;
  assign ovf     = ovf_q;
  assign result  = result_q;
  assign resultE = result_q[31:16];
  assign resultF = result_q[15:0];

endmodule

// File: tb/tb_fixed_divider.sv
// tb_fixed_divider: directed self-checking bench for fixed_divider.
// Honours FIXDIV_ROUND_EN to select expected latency and rounded results.
module tb_fixed_divider;

`ifdef FIXDIV_ROUND_EN
  localparam int LAT = 50;
  localparam logic [31:0] RES_2_3 = 32'h0000_AAAB;
`else
  localparam int LAT = 49;
  localparam logic [31:0] RES_2_3 = 32'h0000_AAAA;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b, c, d;
  logic        busy, done, div0, ovf;
  logic [31:0] result;
  logic [15:0] res_e, res_f;

  int checks = 0;
  int errors = 0;

  fixed_divider dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .busy    (busy),
    .done    (done),
    .div0    (div0),
    .ovf     (ovf),
    .result  (result),
    .resultE (res_e),
    .resultF (res_f)
  );

  always #5 clk = ~clk;

  // Outputs are sampled on the falling edge; cycle k is the cycle after the k-th rising edge.
  task automatic check_idle_zero(input string name);
    checks++;
    if ({busy, done, div0, ovf} !== 4'b0000 || result !== 32'h0 || res_e !== 16'h0 || res_f !== 16'h0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b div0=%b ovf=%b result=%h, required all zero",
               name, busy, done, div0, ovf, result);
    end
  endtask

  task automatic run_div(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic,
                         input logic [15:0] id, input logic [31:0] exp_res, input logic exp_ovf,
                         input logic exp_div0, input int exp_lat, input string name);
    int done_cyc;
    int done_cnt;
    int busy_bad;
    logic [31:0] res_at_done;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; res_at_done = 32'hDEAD_BEEF;
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= exp_lat + 3; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          res_at_done = result;
        end
      end
      if (busy !== ((cyc < exp_lat) && !exp_div0)) busy_bad++;
      if (cyc == 2) begin
        a = 16'h1234; b = 16'h5678; c = 16'h0001; d = 16'h9ABC;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cyc != exp_lat) begin
      errors++; $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_lat);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL %s busy_profile: %0d wrong cycles, required 0", name, busy_bad);
    end
    checks++;
    if (res_at_done !== exp_res) begin
      errors++; $display("FAIL %s result_at_done: got %h required %h", name, res_at_done, exp_res);
    end
    checks++;
    if (result !== exp_res || res_e !== exp_res[31:16] || res_f !== exp_res[15:0]) begin
      errors++;
      $display("FAIL %s result_held: got %h (E=%h F=%h) required %h", name, result, res_e, res_f, exp_res);
    end
    checks++;
    if (ovf !== exp_ovf || div0 !== exp_div0) begin
      errors++;
      $display("FAIL %s flags: got ovf=%b div0=%b required ovf=%b div0=%b", name, ovf, div0, exp_ovf, exp_div0);
    end
  endtask

  task automatic test_reset();
    int dn;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0; d = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_state");
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d done cycles required 0", dn);
    end
  endtask

  task automatic test_basic();
    run_div(16'd1, 16'h8000, 16'd0, 16'h8000, 32'h0003_0000, 1'b0, 1'b0, LAT, "div_1p5_0p5");
    run_div(16'd2, 16'h0000, 16'd3, 16'h0000, RES_2_3, 1'b0, 1'b0, LAT, "div_2_3");
  endtask

  task automatic test_overflow();
    run_div(16'h8000, 16'h0000, 16'd0, 16'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT, "overflow");
  endtask

  task automatic test_div0();
    run_div(16'd5, 16'h0000, 16'd0, 16'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, "div_by_zero");
    run_div(16'd10, 16'h0000, 16'd4, 16'd0, 32'h0002_8000, 1'b0, 1'b0, LAT, "div_10_4");
  endtask

  task automatic test_ignore_and_reset();
    int done_cyc;
    int done_cnt;
    int bad;
    done_cyc = -1; done_cnt = 0;
    @(negedge clk);
    a = 16'd10; b = 16'h0; c = 16'd4; d = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= LAT + 3; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      start = (cyc == 5 || cyc == 30);
      if (start) begin
        a = 16'd1; b = 16'h0; c = 16'd1; d = 16'h0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_cyc != LAT || done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_start done: got cycle %0d count %0d required cycle %0d count 1", done_cyc, done_cnt, LAT);
    end
    checks++;
    if (result !== 32'h0002_8000) begin
      errors++; $display("FAIL ignore_start result: got %h required 00028000", result);
    end
    // Second division aborted by reset in cycle 20.
    a = 16'd1; b = 16'h8000; c = 16'd0; d = 16'h8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_calc_reset");
    bad = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL post_reset_quiet: got %0d active cycles required 0", bad);
    end
    run_div(16'd10, 16'h0000, 16'd4, 16'd0, 32'h0002_8000, 1'b0, 1'b0, LAT, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_div0();
    test_ignore_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
